// File: rtl/button_debounce_multi_if.sv
// button_debounce_multi_if: raw button inputs and debounced outputs.
// Ports: but_in (raw, active-low), but_deb_o, press_p, release_p, long_p.
interface button_debounce_multi_if #(
  parameter int CH = 4
);
  logic [CH-1:0] but_in;
  logic [CH-1:0] but_deb_o;
  logic [CH-1:0] press_p;
  logic [CH-1:0] release_p;
  logic [CH-1:0] long_p;

  modport master (
    output but_in,
    input  but_deb_o,
    input  press_p,
    input  release_p,
    input  long_p
  );

  modport slave (
    input  but_in,
    output but_deb_o,
    output press_p,
    output release_p,
    output long_p
  );
endinterface

// File: rtl/button_debounce_multi.sv
// button_debounce_multi: per-channel sync, debounce, press/release/long pulses.
// Ports: clk, rst (sync, active-high), bus (slave: but_in in, level+pulses out).
module button_debounce_multi #(
  parameter int CH       = 4,
  parameter int DEB_CYC  = 1000000,
  parameter int LONG_CYC = 50000000,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic rst,
  button_debounce_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PCHK,
    HELD,
    RCHK
  } state_e;

  logic [CH-1:0] deb_v;
  logic [CH-1:0] press_v;
  logic [CH-1:0] rel_v;
  logic [CH-1:0] long_v;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic             s1_q, s2_q;
    state_e           st_q, st_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             done_q, done_d;
    logic             deb_q, deb_d;
    logic             pp_q, pp_d;
    logic             rp_q, rp_d;
    logic             lp_q, lp_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q   <= 1'b1;
        s2_q   <= 1'b1;
        st_q   <= IDLE;
        dcnt_q <= '0;
        hcnt_q <= '0;
        done_q <= 1'b0;
        deb_q  <= 1'b1;
        pp_q   <= 1'b0;
        rp_q   <= 1'b0;
        lp_q   <= 1'b0;
      end else begin
        s1_q   <= bus.but_in[g];
        s2_q   <= s1_q;
        st_q   <= st_d;
        dcnt_q <= dcnt_d;
        hcnt_q <= hcnt_d;
        done_q <= done_d;
        deb_q  <= deb_d;
        pp_q   <= pp_d;
        rp_q   <= rp_d;
        lp_q   <= lp_d;
      end
    end

    always_comb begin
      st_d   = st_q;
      dcnt_d = dcnt_q;
      hcnt_d = hcnt_q;
      done_d = done_q;
      pp_d   = 1'b0;
      rp_d   = 1'b0;
      lp_d   = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (!s2_q) begin
            st_d   = PCHK;
            dcnt_d = '0;
          end
        end
        PCHK: begin
          if (s2_q) begin
            st_d   = IDLE;
            dcnt_d = '0;
          end else if (dcnt_q == DEB_MAX) begin
            st_d   = HELD;
            pp_d   = 1'b1;
            hcnt_d = '0;
            done_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        HELD: begin
          // Long-press match and a release candidate may coincide.
          if (!done_q) begin
            if (hcnt_q == LONG_MAX) begin
              lp_d   = 1'b1;
              done_d = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          if (s2_q) begin
            st_d   = RCHK;
            dcnt_d = '0;
          end
        end
        RCHK: begin
          if (!s2_q) begin
            st_d = HELD;
          end else if (dcnt_q == DEB_MAX) begin
            st_d = IDLE;
            rp_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          st_d = IDLE;
        end
      endcase
      deb_d = (st_d == IDLE) || (st_d == PCHK);
    end

    assign deb_v[g]   = deb_q;
    assign press_v[g] = pp_q;
    assign rel_v[g]   = rp_q;
    assign long_v[g]  = lp_q;
  end

  assign bus.but_deb_o = deb_v;
  assign bus.press_p   = press_v;
  assign bus.release_p = rel_v;
  assign bus.long_p    = long_v;

endmodule

// File: tb/tb_button_debounce_multi.sv
// tb_button_debounce_multi: directed and random stimulus vs run-length model.
// Ports: none; drives the DUT through button_debounce_multi_if.
module tb_button_debounce_multi;

  localparam int CH   = 4;
  localparam int DEB  = 8;
  localparam int LONG = 40;
  localparam int W    = 32;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_debounce_multi_if #(.CH(CH)) bif ();

  button_debounce_multi #(
    .CH      (CH),
    .DEB_CYC (DEB),
    .LONG_CYC(LONG),
    .CNT_W   (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int n_tot = 0;
  int n_bad = 0;

  // Model: synchroniser delay line, debounced level, length of the
  // current run of samples that disagree with the level, count of
  // cycles spent settled in the pressed state, long-fired flag.
  logic ms1 [CH];
  logic ms2 [CH];
  logic mdeb[CH];
  int   run [CH];
  int   held[CH];
  bit   done[CH];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [CH-1:0] b, input logic r);
    logic [CH-1:0] ep, er, el, ed;
    logic x;
    ep = '0;
    er = '0;
    el = '0;
    @(negedge clk);
    bif.but_in = b;
    rst = r;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        ms1[c]  = 1'b1;
        ms2[c]  = 1'b1;
        mdeb[c] = 1'b1;
        run[c]  = 0;
        held[c] = 0;
        done[c] = 1'b0;
      end else begin
        x = ms2[c];
        if (!mdeb[c] && run[c] == 0 && !done[c]) begin
          held[c]++;
          if (held[c] == LONG) begin
            el[c]   = 1'b1;
            done[c] = 1'b1;
          end
        end
        if (x != mdeb[c]) begin
          run[c]++;
          if (run[c] == DEB + 1) begin
            if (mdeb[c]) begin
              ep[c]   = 1'b1;
              held[c] = 0;
              done[c] = 1'b0;
            end else begin
              er[c] = 1'b1;
            end
            mdeb[c] = ~mdeb[c];
            run[c]  = 0;
          end
        end else begin
          run[c] = 0;
        end
        ms2[c] = ms1[c];
        ms1[c] = b[c];
      end
      ed[c] = mdeb[c];
    end
    check("deb",   32'(bif.but_deb_o), 32'(ed));
    check("press", 32'(bif.press_p),   32'(ep));
    check("rel",   32'(bif.release_p), 32'(er));
    check("long",  32'(bif.long_p),    32'(el));
  endtask

  // Edges (after the last step) until the chosen pulse on channel ch.
  task automatic lat_to(input int ch, input int kind,
                        input logic [CH-1:0] b, input int maxn,
                        output int lat);
    logic [CH-1:0] v;
    lat = -1;
    for (int i = 1; i <= maxn; i++) begin
      step(b, 1'b0);
      v = (kind == K_PRESS) ? bif.press_p :
          (kind == K_REL)   ? bif.release_p : bif.long_p;
      if (v[ch]) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int p0, p2;
  int rem[CH];
  logic [CH-1:0] lv;
  int rcnt;

  initial begin
    bif.but_in = '1;
    for (int c = 0; c < CH; c++) begin
      ms1[c] = 1'b1; ms2[c] = 1'b1; mdeb[c] = 1'b1;
      run[c] = 0; held[c] = 0; done[c] = 1'b0;
    end
    repeat (3) step('1, 1'b1);
    check("rst_deb", 32'(bif.but_deb_o), 32'hF);
    check("rst_pulse", 32'(bif.press_p | bif.release_p | bif.long_p), 0);
    repeat (3) step('1, 1'b0);

    // 1: clean press and release on ch0.
    step(4'hE, 1'b0);
    lat_to(0, K_PRESS, 4'hE, 20, lat);
    check("t1_press_lat", lat, 10);
    check("t1_deb", 32'(bif.but_deb_o[0]), 0);
    repeat (19) step(4'hE, 1'b0);
    step(4'hF, 1'b0);
    lat_to(0, K_REL, 4'hF, 20, lat);
    check("t1_rel_lat", lat, 10);
    repeat (5) step(4'hF, 1'b0);

    // 2: bounce rejection on ch1, then a lone 7-cycle glitch.
    repeat (6) begin
      repeat (5) step(4'hD, 1'b0);
      step(4'hF, 1'b0);
    end
    step(4'hD, 1'b0);
    lat_to(1, K_PRESS, 4'hD, 20, lat);
    check("t2_press_lat", lat, 10);
    repeat (10) step(4'hD, 1'b0);
    repeat (15) step(4'hF, 1'b0);
    repeat (7) step(4'hD, 1'b0);
    repeat (15) step(4'hF, 1'b0);

    // 3: long press on ch2.
    step(4'hB, 1'b0);
    lat_to(2, K_PRESS, 4'hB, 20, lat);
    check("t3_press_lat", lat, 10);
    lat_to(2, K_LONG, 4'hB, 60, lat);
    check("t3_long_lat", lat, 40);
    repeat (50) step(4'hB, 1'b0);
    step(4'hF, 1'b0);
    lat_to(2, K_REL, 4'hF, 20, lat);
    check("t3_rel_lat", lat, 10);

    // 4: release bounce during hold on ch3.
    step(4'h7, 1'b0);
    lat_to(3, K_PRESS, 4'h7, 20, lat);
    check("t4_press_lat", lat, 10);
    repeat (19) step(4'h7, 1'b0);
    repeat (3) step(4'hF, 1'b0);
    lat_to(3, K_LONG, 4'h7, 60, lat);
    check("t4_long_lat", lat + 22, 43);
    check("t4_deb", 32'(bif.but_deb_o[3]), 0);
    repeat (5) step(4'hF, 1'b0);
    repeat (15) step(4'hF, 1'b0);

    // 5: ch0 and ch2 together.
    p0 = -1;
    p2 = -1;
    step(4'hA, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(4'hA, 1'b0);
      if (bif.press_p[0] && p0 < 0) p0 = i;
      if (bif.press_p[2] && p2 < 0) p2 = i;
    end
    check("t5_p0", p0, 10);
    check("t5_p2", p2, 10);
    repeat (15) step(4'hF, 1'b0);

    // 6: reset mid-hold with ch0 kept low through reset.
    step(4'hE, 1'b0);
    lat_to(0, K_PRESS, 4'hE, 20, lat);
    check("t6_press_lat", lat, 10);
    repeat (20) step(4'hE, 1'b0);
    step(4'hE, 1'b1);
    check("t6_rst_deb", 32'(bif.but_deb_o), 32'hF);
    step(4'hE, 1'b0);
    lat_to(0, K_PRESS, 4'hE, 20, lat);
    check("t6_repress_lat", lat, 10);
    lat_to(0, K_LONG, 4'hE, 60, lat);
    check("t6_long_lat", lat, 40);
    repeat (20) step(4'hF, 1'b0);

    // Random segments: bounces, mid-length and long holds, rare resets.
    for (int c = 0; c < CH; c++) begin
      rem[c] = 0;
      lv[c]  = 1'b1;
    end
    rcnt = 0;
    for (int n = 0; n < 8000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          lv[c] = ~lv[c];
          case ($urandom_range(0, 2))
            0: rem[c] = $urandom_range(1, 7);
            1: rem[c] = $urandom_range(8, 30);
            default: rem[c] = $urandom_range(41, 120);
          endcase
        end
        rem[c]--;
      end
      if (rcnt == 0 && $urandom_range(0, 799) == 0) begin
        rcnt = $urandom_range(1, 3);
      end
      step(lv, rcnt != 0);
      if (rcnt != 0) rcnt--;
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
